// File: rtl/conv_pkg.sv
`default_nettype none
// ==== conv_pkg : state encoding, width helpers and ReLU helper for conv2d_stream_engine (rev 1.0) ====
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_MAC     = 3'd2,
    S_OUT     = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Bits needed to index n items; never zero so K=1 still yields legal ports.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic relu_pass(input logic sign_bit);
    return !sign_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ==== conv_line_buffer : K x IMG_W row store with circular row pointer (rev 1.0) ====
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int IMG_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        retire_i,
  input  logic                        we_i,
  input  logic [idx_w(K)-1:0]         wr_ky_i,
  input  logic [idx_w(IMG_W)-1:0]     wr_col_i,
  input  logic signed [DATA_W-1:0]    wdata_i,
  input  logic [idx_w(K)-1:0]         rd_ky_i,
  input  logic [idx_w(IMG_W)-1:0]     rd_col_i,
  output logic signed [DATA_W-1:0]    rd_data_o
);
  localparam int KY_W = idx_w(K);
  localparam int KW1  = KY_W + 1;

  logic [KY_W-1:0]          base_q, base_d;
  logic signed [DATA_W-1:0] mem_q [K][IMG_W];

  // Logical row ky (0 = oldest) to physical storage row.
  function automatic logic [KY_W-1:0] phys(input logic [KY_W-1:0] b, input logic [KY_W-1:0] ky);
    logic [KY_W:0] s;
    s = {1'b0, b} + {1'b0, ky};
    if (s >= KW1'(K)) s = s - KW1'(K);
    return s[KY_W-1:0];
  endfunction

  always_comb begin
    base_d = base_q;
    if (clr_i)         base_d = '0;
    else if (retire_i) base_d = phys(base_q, KY_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) base_q <= '0;
    else     base_q <= base_d;
  end

  always_ff @(posedge clk) begin
    if (we_i) mem_q[phys(base_q, wr_ky_i)][wr_col_i] <= wdata_i;
  end

  assign rd_data_o = mem_q[phys(base_q, rd_ky_i)][rd_col_i];
endmodule
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ==== mac_unit : signed multiply-accumulate, wraps modulo 2^ACC_W (rev 1.0) ====
module mac_unit #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    prod  = P_W'(a_i) * P_W'(b_i);
    acc_d = acc_q;
    if (en_i) acc_d = (clr_i ? '0 : acc_q) + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule
`default_nettype wire

// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// ==== conv2d_stream_engine : streamed stride-1 valid KxK convolution, one MAC (rev 1.0) ====
// Optional CONV_RELU_EN clamps negative results to zero.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      kern_we,
  input  logic [idx_w(K*K)-1:0]     kern_addr,
  input  logic signed [COEF_W-1:0]  kern_wdata,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic signed [DATA_W-1:0]  pix_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_data,
  output logic                      busy,
  output logic                      done
);
  localparam int TAP_W = idx_w(K*K);
  localparam int KY_W  = idx_w(K);
  localparam int COL_W = idx_w(IMG_W);
  localparam int ROW_W = idx_w(IMG_H);

  localparam logic [TAP_W-1:0] C_TAPS     = TAP_W'(K*K);
  localparam logic [TAP_W-1:0] C_LAST_TAP = TAP_W'(K*K-1);
  localparam logic [KY_W-1:0]  C_LAST_K   = KY_W'(K-1);
  localparam logic [COL_W-1:0] C_LAST_PIX = COL_W'(IMG_W-1);
  localparam logic [COL_W-1:0] C_LAST_WIN = COL_W'(IMG_W-K);
  localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(IMG_H-K);

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d, wr_col_q, wr_col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [KY_W-1:0]          ky_q, ky_d, kx_q, kx_d, wr_ky_q, wr_ky_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic signed [COEF_W-1:0] coef_q [K*K];
  logic                     pix_xfer, lb_clr, lb_retire, mac_en;
  logic signed [DATA_W-1:0] tap_pix;
  logic signed [ACC_W-1:0]  acc;

  assign pix_ready = (state_q == S_FILL) || (state_q == S_ADVANCE);
  assign pix_xfer  = pix_valid && pix_ready;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_col_d  = wr_col_q;
    wr_ky_d   = wr_ky_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    tap_d     = tap_q;
    out_valid = 1'b0;
    done      = 1'b0;
    lb_clr    = 1'b0;
    lb_retire = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_FILL;
        col_d    = '0;
        row_d    = '0;
        wr_col_d = '0;
        wr_ky_d  = '0;
        lb_clr   = 1'b1;
      end
      // ADVANCE re-enters with wr_ky = K-1, so it refills exactly one row.
      S_FILL, S_ADVANCE: if (pix_xfer) begin
        wr_col_d = wr_col_q + 1'b1;
        if (wr_col_q == C_LAST_PIX) begin
          wr_col_d = '0;
          if (wr_ky_q == C_LAST_K) begin
            state_d = S_MAC;
            col_d   = '0;
            ky_d    = '0;
            kx_d    = '0;
            tap_d   = '0;
            if (state_q == S_ADVANCE) row_d = row_q + 1'b1;
          end else begin
            wr_ky_d = wr_ky_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        tap_d  = tap_q + 1'b1;
        kx_d   = kx_q + 1'b1;
        if (kx_q == C_LAST_K) begin
          kx_d = '0;
          ky_d = ky_q + 1'b1;
        end
        if (tap_q == C_LAST_TAP) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ky_d  = '0;
          kx_d  = '0;
          tap_d = '0;
          if (col_q != C_LAST_WIN) begin
            col_d   = col_q + 1'b1;
            state_d = S_MAC;
          end else if (row_q == C_LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ADVANCE;
            lb_retire = 1'b1;
            wr_ky_d   = C_LAST_K;
            wr_col_d  = '0;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      wr_col_q <= '0;
      wr_ky_q  <= '0;
      ky_q     <= '0;
      kx_q     <= '0;
      tap_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wr_col_q <= wr_col_d;
      wr_ky_q  <= wr_ky_d;
      ky_q     <= ky_d;
      kx_q     <= kx_d;
      tap_q    <= tap_d;
    end
  end

  // Kernel is only writable in IDLE, so it stays frozen for a whole image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K*K; i++) coef_q[i] <= '0;
    end else if (state_q == S_IDLE && kern_we && kern_addr < C_TAPS) begin
      coef_q[kern_addr] <= kern_wdata;
    end
  end

  conv_line_buffer #(.K(K), .IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (lb_clr),
    .retire_i  (lb_retire),
    .we_i      (pix_xfer),
    .wr_ky_i   (wr_ky_q),
    .wr_col_i  (wr_col_q),
    .wdata_i   (pix_data),
    .rd_ky_i   (ky_q),
    .rd_col_i  (col_q + COL_W'(kx_q)),
    .rd_data_o (tap_pix)
  );

  mac_unit #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mac_en),
    .clr_i (tap_q == '0),
    .a_i   (tap_pix),
    .b_i   (coef_q[tap_q]),
    .acc_o (acc)
  );

`ifdef CONV_RELU_EN
  assign out_data = relu_pass(acc[ACC_W-1]) ? acc : '0;
`else
  assign out_data = acc;
`endif

endmodule
`default_nettype wire
